// File: rtl/alu_mul_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer_pkg
// Shared constants and types for the ALU-stage multiply sequencer:
//   - control-unit decode values that identify an R-type MUL
//   - operand width
//   - sequencer state encoding
//   - is_mul_op() helper used by the sequencer decode
// ---------------------------------------------------------------------------
package alu_mul_sequencer_pkg;

    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [5:0] FUNCT_MUL    = 6'h18;

    localparam int OP_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    function automatic logic is_mul_op(input logic [1:0] op, input logic [5:0] funct);
        return (op == ALU_OP_RTYPE) && (funct == FUNCT_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer_if
// Issue/result bundle between decode (master) and the multiply sequencer
// (slave).
//   issue_valid   decode presents an op this cycle
//   issue_ready   sequencer can accept an op
//   alu_op        ALU_OP from the control unit
//   alu_function  funct field, instruction[5:0]
//   opA / opB     multiplicand / multiplier
//   flush         synchronous pipeline flush
//   stall         freeze fetch/decode and ALU-stage input registers
//   busy          multiply sequence in progress
//   mul_valid     product valid, one cycle
//   mul_result    low 32 bits of opA*opB
// ---------------------------------------------------------------------------
interface alu_mul_sequencer_if;
    import alu_mul_sequencer_pkg::*;

    logic            issue_valid;
    logic            issue_ready;
    logic [1:0]      alu_op;
    logic [5:0]      alu_function;
    logic [OP_W-1:0] opA;
    logic [OP_W-1:0] opB;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            mul_valid;
    logic [OP_W-1:0] mul_result;

    modport master (
        output issue_valid, alu_op, alu_function, opA, opB, flush,
        input  issue_ready, stall, busy, mul_valid, mul_result
    );

    modport slave (
        input  issue_valid, alu_op, alu_function, opA, opB, flush,
        output issue_ready, stall, busy, mul_valid, mul_result
    );

endinterface

// File: rtl/alu_mul_sequencer_mul_shift_add.sv
// ---------------------------------------------------------------------------
// mul_shift_add
// Shift-add datapath for the iterative multiplier. One step per cycle:
// conditionally add the multiplicand into the accumulator, then shift the
// multiplicand left and the multiplier right.
// Ports:
//   clk, reset   clock / async active-high reset
//   load         capture operands, clear acc and cnt
//   step         perform one shift-add iteration
//   clear        drop any sequence in progress (highest priority after reset)
//   load_mcand   multiplicand to capture on load
//   load_mplier  multiplier to capture on load
//   acc          accumulator (low 32 bits of the running product)
//   last         the current step is the final one of the sequence
// ---------------------------------------------------------------------------
module mul_shift_add
    import alu_mul_sequencer_pkg::*;
#(
    parameter int MUL_ITER   = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            clear,
    input  logic [OP_W-1:0] load_mcand,
    input  logic [OP_W-1:0] load_mplier,
    output logic [OP_W-1:0] acc,
    output logic            last
);

    localparam int             CNT_W    = $clog2(MUL_ITER) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    logic [OP_W-1:0]  mcand_q;
    logic [OP_W-1:0]  mplier_q;
    logic [OP_W-1:0]  acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mplier_next_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (clear) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= load_mcand;
            mplier_q <= load_mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // Multiplier after this step's shift is zero iff no bits above bit 0 remain.
    assign mplier_next_zero = (mplier_q[OP_W-1:1] == '0);

    assign last = (cnt_q == CNT_LAST) || (EARLY_EXIT && mplier_next_zero);
    assign acc  = acc_q;

endmodule

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
// Issue-side controller for the ALU stage. Single-cycle ops pass through
// without any effect here; R-type MUL is run as an iterative shift-add
// sequence while the upstream pipeline is held by stall.
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset, clears all state
//   bus     alu_mul_sequencer_if.slave (issue handshake, operands, flush,
//           stall/busy status and registered product)
// Parameters:
//   MUL_ITER    maximum shift-add iterations (operand width)
//   EARLY_EXIT  1: stop once the remaining multiplier is zero
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no multiply in flight, ready to accept
// S_RUN  | shift-add iterations in progress, upstream stalled
// S_DONE | product presented for one cycle, may accept the next op
// ---------------------------------------------------------------------------
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int MUL_ITER   = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    alu_mul_sequencer_if.slave  bus
);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic            is_mul;
    logic            accept;
    logic            load;
    logic            step;
    logic            clear;
    logic            last;
    logic            mul_valid_q;
    logic [OP_W-1:0] acc;

    assign is_mul = is_mul_op(bus.alu_op, bus.alu_function);

    // Reset gates accept so stall reads low while reset is held even if
    // decode keeps presenting a MUL.
    assign accept = bus.issue_valid && bus.issue_ready && !bus.flush && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mul_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // DONE is only ever entered from the final RUN step.
            mul_valid_q <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        if (bus.flush) begin
            state_d = S_IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept && is_mul) begin
                        load    = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    step = 1'b1;
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    mul_shift_add #(
        .MUL_ITER   (MUL_ITER),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_mul_shift_add (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .clear       (clear),
        .load_mcand  (bus.opA),
        .load_mplier (bus.opB),
        .acc         (acc),
        .last        (last)
    );

    assign bus.issue_ready = (state_q != S_RUN);
    assign bus.busy        = (state_q == S_RUN);
    assign bus.stall       = (state_q == S_RUN) || (accept && is_mul);
    assign bus.mul_valid   = mul_valid_q;
    // The accumulator is already a register and holds the final product
    // through the DONE cycle.
    assign bus.mul_result  = acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        iv_e;
    logic        iv_n;
    logic        fl;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] opa;
    logic [31:0] opb;

    int checks;
    int errors;

    logic        s_stall;
    logic        s_busy;
    logic        s_ready;
    logic        s_valid;
    logic [31:0] s_result;

    alu_mul_sequencer_if bus_e();
    alu_mul_sequencer_if bus_n();

    assign bus_e.issue_valid  = iv_e;
    assign bus_e.alu_op       = op;
    assign bus_e.alu_function = fn;
    assign bus_e.opA          = opa;
    assign bus_e.opB          = opb;
    assign bus_e.flush        = fl;

    assign bus_n.issue_valid  = iv_n;
    assign bus_n.alu_op       = op;
    assign bus_n.alu_function = fn;
    assign bus_n.opA          = opa;
    assign bus_n.opB          = opb;
    assign bus_n.flush        = fl;

    alu_mul_sequencer #(.MUL_ITER(32), .EARLY_EXIT(1'b1)) dut_e (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_e)
    );

    alu_mul_sequencer #(.MUL_ITER(32), .EARLY_EXIT(1'b0)) dut_n (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic sample(input bit sel);
        if (sel) begin
            s_stall  = bus_n.stall;
            s_busy   = bus_n.busy;
            s_ready  = bus_n.issue_ready;
            s_valid  = bus_n.mul_valid;
            s_result = bus_n.mul_result;
        end else begin
            s_stall  = bus_e.stall;
            s_busy   = bus_e.busy;
            s_ready  = bus_e.issue_ready;
            s_valid  = bus_e.mul_valid;
            s_result = bus_e.mul_result;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            sample(s == 1);
            chk({tag, "_valid"},  {31'd0, s_valid}, 32'd0);
            chk({tag, "_result"}, s_result,         32'd0);
            chk({tag, "_busy"},   {31'd0, s_busy},  32'd0);
            chk({tag, "_stall"},  {31'd0, s_stall}, 32'd0);
            chk({tag, "_ready"},  {31'd0, s_ready}, 32'd1);
        end
    endtask

    // Number of RUN cycles: highest set bit position + 1 (at least 1) with
    // early exit, otherwise always the full operand width.
    function automatic int model_k(input bit no_exit, input logic [31:0] b);
        int k;
        k = 1;
        if (no_exit) return 32;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) k = i + 1;
        end
        return k;
    endfunction

    function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // Presents a MUL to the selected DUT now, checks every RUN cycle and
    // returns inside the DONE cycle after checking the product.
    task automatic run_mul(input bit sel, input logic [31:0] a, input logic [31:0] b);
        int          k;
        logic [31:0] want;
        k    = model_k(sel, b);
        want = model_prod(a, b);
        op   = ALU_OP_RTYPE;
        fn   = FUNCT_MUL;
        opa  = a;
        opb  = b;
        iv_e = !sel;
        iv_n = sel;
        #1;
        sample(sel);
        chk("accept_stall", {31'd0, s_stall}, 32'd1);
        chk("accept_ready", {31'd0, s_ready}, 32'd1);
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            iv_e = 1'b0;
            iv_n = 1'b0;
            opa  = $urandom;
            opb  = $urandom;
            #1;
            sample(sel);
            chk("run_stall", {31'd0, s_stall}, 32'd1);
            chk("run_busy",  {31'd0, s_busy},  32'd1);
            chk("run_ready", {31'd0, s_ready}, 32'd0);
            chk("run_valid", {31'd0, s_valid}, 32'd0);
        end
        @(posedge clk); #1;
        iv_e = 1'b0;
        iv_n = 1'b0;
        #1;
        sample(sel);
        chk("done_valid",  {31'd0, s_valid}, 32'd1);
        chk("done_result", s_result,         want);
        chk("done_stall",  {31'd0, s_stall}, 32'd0);
        chk("done_busy",   {31'd0, s_busy},  32'd0);
        chk("done_ready",  {31'd0, s_ready}, 32'd1);
    endtask

    task automatic idle_after(input bit sel);
        @(posedge clk); #1;
        iv_e = 1'b0;
        iv_n = 1'b0;
        #1;
        sample(sel);
        chk("post_valid", {31'd0, s_valid}, 32'd0);
        chk("post_busy",  {31'd0, s_busy},  32'd0);
        chk("post_ready", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic flush_mid_run(input bit sel);
        @(posedge clk); #1;
        op   = ALU_OP_RTYPE;
        fn   = FUNCT_MUL;
        opa  = 32'h0000_1234;
        opb  = 32'h0001_0000;
        iv_e = !sel;
        iv_n = sel;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            iv_e = 1'b0;
            iv_n = 1'b0;
            if (c == 5) fl = 1'b1;
            #1;
            sample(sel);
            chk("flush_pre_busy", {31'd0, s_busy}, 32'd1);
        end
        @(posedge clk); #1;
        fl = 1'b0;
        #1;
        sample(sel);
        chk("flush_busy",  {31'd0, s_busy},  32'd0);
        chk("flush_ready", {31'd0, s_ready}, 32'd1);
        chk("flush_stall", {31'd0, s_stall}, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            sample(sel);
            chk("flush_no_valid", {31'd0, s_valid}, 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        iv_e = 1'b0;
        iv_n = 1'b0;
        fl   = 1'b0;
        op   = 2'b00;
        fn   = 6'h00;
        opa  = 32'd0;
        opb  = 32'd0;

        #2;
        chk_reset_outputs("init_rst");
        #10;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("released");

        // Single-cycle ADD and a non-R-type op with a MUL funct pass through.
        @(posedge clk); #1;
        op   = ALU_OP_RTYPE;
        fn   = 6'h20;
        opa  = 32'd10;
        opb  = 32'd20;
        iv_e = 1'b1;
        iv_n = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s == 1);
            chk("add_stall", {31'd0, s_stall}, 32'd0);
            chk("add_ready", {31'd0, s_ready}, 32'd1);
        end
        @(posedge clk); #1;
        op = 2'b00;
        fn = FUNCT_MUL;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s == 1);
            chk("nonr_stall", {31'd0, s_stall}, 32'd0);
            chk("nonr_busy",  {31'd0, s_busy},  32'd0);
        end
        @(posedge clk); #1;
        iv_e = 1'b0;
        iv_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            for (int s = 0; s < 2; s++) begin
                sample(s == 1);
                chk("add_no_valid", {31'd0, s_valid}, 32'd0);
                chk("add_no_busy",  {31'd0, s_busy},  32'd0);
            end
        end

        // Directed products.
        @(posedge clk); #1;
        run_mul(1'b0, 32'd3, 32'd5);
        idle_after(1'b0);
        @(posedge clk); #1;
        run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle_after(1'b1);
        @(posedge clk); #1;
        run_mul(1'b0, 32'hCAFE_F00D, 32'd0);
        idle_after(1'b0);
        @(posedge clk); #1;
        run_mul(1'b0, 32'h0000_0003, 32'h8000_0000);
        idle_after(1'b0);
        @(posedge clk); #1;
        run_mul(1'b1, 32'h1234_5678, 32'd0);
        idle_after(1'b1);

        // Back-to-back: second MUL accepted in the first one's DONE cycle.
        @(posedge clk); #1;
        run_mul(1'b0, 32'd3, 32'd5);
        run_mul(1'b0, 32'd7, 32'd6);
        idle_after(1'b0);
        @(posedge clk); #1;
        run_mul(1'b1, 32'd100, 32'd3);
        run_mul(1'b1, 32'hFFFF_FFFE, 32'd7);
        idle_after(1'b1);

        // Flush in DONE keeps that cycle's product visible.
        @(posedge clk); #1;
        run_mul(1'b0, 32'd9, 32'd11);
        fl = 1'b1;
        #1;
        sample(1'b0);
        chk("flush_done_valid", {31'd0, s_valid}, 32'd1);
        @(posedge clk); #1;
        fl = 1'b0;
        #1;
        sample(1'b0);
        chk("flush_done_after_valid", {31'd0, s_valid}, 32'd0);
        chk("flush_done_after_busy",  {31'd0, s_busy},  32'd0);

        // Flush mid-RUN on both variants.
        flush_mid_run(1'b0);
        flush_mid_run(1'b1);

        // Flush wins over a simultaneous MUL issue.
        @(posedge clk); #1;
        op   = ALU_OP_RTYPE;
        fn   = FUNCT_MUL;
        opa  = 32'd5;
        opb  = 32'd5;
        iv_e = 1'b1;
        iv_n = 1'b1;
        fl   = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s == 1);
            chk("flush_issue_stall", {31'd0, s_stall}, 32'd0);
        end
        @(posedge clk); #1;
        iv_e = 1'b0;
        iv_n = 1'b0;
        fl   = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s == 1);
            chk("flush_issue_busy", {31'd0, s_busy}, 32'd0);
        end

        // Reset during the DONE cycle clears the product immediately.
        @(posedge clk); #1;
        run_mul(1'b0, 32'h0001_2345, 32'd7);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_done");
        rst = 1'b0;

        // Reset mid-RUN with a MUL still being presented.
        @(posedge clk); #1;
        op   = ALU_OP_RTYPE;
        fn   = FUNCT_MUL;
        opa  = 32'hDEAD_BEEF;
        opb  = 32'hFFFF_0000;
        iv_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            iv_n = 1'b0;
        end
        #1;
        sample(1'b1);
        chk("pre_rst_busy", {31'd0, s_busy}, 32'd1);
        iv_n = 1'b1;
        iv_e = 1'b1;
        rst  = 1'b1;
        #1;
        chk_reset_outputs("rst_run");
        iv_n = 1'b0;
        iv_e = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_mul(1'b1, 32'h0000_0013, 32'h0000_0011);
        idle_after(1'b1);
        @(posedge clk); #1;
        run_mul(1'b0, 32'h0000_0013, 32'h0000_0011);
        idle_after(1'b0);

        // Randomized products with varied multiplier widths.
        for (int r = 0; r < 16; r++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          sel;
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            sel = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            run_mul(sel, a, b);
            if ($urandom_range(0, 1) == 1) begin
                run_mul(sel, $urandom, $urandom >> $urandom_range(0, 31));
            end
            idle_after(sel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
